// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC select, IF PC register, inst-SRAM request
// and a one-entry buffer holding the fetched word while ID stalls.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_allow_in,
    input  logic [33:0] id_to_if_bus,
    output logic        if_to_id_valid,
    output logic [63:0] if_to_id_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    logic        br_taken;
    logic [31:0] br_target;
    logic        br_cancel;
    logic        br_pending;

    logic        to_fs_valid;
    logic [31:0] nextpc;

    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        fs_ready_go;
    logic        fs_allow_in;

    logic        buf_valid;
    logic [31:0] inst_buf;
    logic        buf_capture;
    logic [31:0] fs_inst;

    assign br_taken   = id_to_if_bus[33];
    assign br_target  = id_to_if_bus[32:1];
    assign br_cancel  = id_to_if_bus[0];
    assign br_pending = br_taken && !br_cancel;

    assign to_fs_valid = reset;
    assign nextpc      = br_cancel ? br_target : fs_pc + 32'd4;

    // A cancelling branch redirects fetch even when ID itself is stalled.
    assign fs_ready_go = 1'b1;
    assign fs_allow_in = (!fs_valid || (fs_ready_go && id_allow_in) || br_cancel)
                         && !br_pending;

    assign buf_capture = fs_valid && !buf_valid && !fs_allow_in && !br_cancel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fs_valid <= 1'b0;
            fs_pc    <= RESET_PC - 32'd4;
        end else if (fs_allow_in) begin
            fs_valid <= to_fs_valid;
            fs_pc    <= nextpc;
        end
    end

    // SRAM output is only trustworthy the cycle after a request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_valid <= 1'b0;
            inst_buf  <= 32'b0;
        end else if (fs_allow_in) begin
            buf_valid <= 1'b0;
        end else if (buf_capture) begin
            buf_valid <= 1'b1;
            inst_buf  <= inst_sram_rdata;
        end
    end

    assign fs_inst = buf_valid ? inst_buf : inst_sram_rdata;

    assign if_to_id_valid = fs_valid && !br_cancel;
    assign if_to_id_bus   = {fs_inst, fs_pc};

    assign inst_sram_en    = to_fs_valid && fs_allow_in;
    assign inst_sram_we    = 4'b0;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'b0;

endmodule

// File: tb/tb_if_stage.sv
// Randomised bench for if_stage against a model of which PC ID should see
// and which instruction word belongs to that PC.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam logic [31:0] SCRAMBLE = 32'ha5a55a5a;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_allow_in;
    logic [33:0] id_to_if_bus;
    logic        if_to_id_valid;
    logic [63:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_allow_in     (id_allow_in),
        .id_to_if_bus    (id_to_if_bus),
        .if_to_id_valid  (if_to_id_valid),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ SCRAMBLE;
    endfunction

    // Registered-read SRAM; output is junk whenever no request was made.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= mem(inst_sram_addr);
        else              inst_sram_rdata <= $urandom;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: the PC currently held for ID and whether it is live.
    logic        m_valid;
    logic [31:0] m_pc;

    initial begin
        logic        tk, cn, adv;
        logic [31:0] tg, exp_addr;
        int          r;

        reset = 1'b0;
        id_allow_in = 1'b0;
        id_to_if_bus = '0;
        inst_sram_rdata = 32'h0;
        m_valid = 1'b0;
        m_pc = RESET_PC - 32'd4;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(if_to_id_valid), 64'd0);
        chk("rst_en", 64'(inst_sram_en), 64'd0);
        chk("rst_we", 64'(inst_sram_we), 64'd0);
        chk("rst_wdata", 64'(inst_sram_wdata), 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 2000; i++) begin
            if (i % 250 == 249) begin
                reset = 1'b0;
                id_to_if_bus = '0;
                #2;
                chk("midrst_valid", 64'(if_to_id_valid), 64'd0);
                chk("midrst_en", 64'(inst_sram_en), 64'd0);
                #2;
                reset = 1'b1;
                m_valid = 1'b0;
                m_pc = RESET_PC - 32'd4;
            end

            r = $urandom_range(0, 9);
            tg = {16'h1c00, 16'($urandom) & 16'hfffc};
            tk = 1'b0;
            cn = 1'b0;
            id_allow_in = ($urandom_range(0, 2) != 0);
            if (i < 8) begin
                id_allow_in = 1'b1;
            end else if (i % 250 >= 244) begin
                id_allow_in = 1'b0;
            end else if (r == 0) begin
                tk = 1'b1;
                cn = 1'b1;
            end else if (r == 1) begin
                tk = 1'b1;
            end
            id_to_if_bus = {tk, tg, cn};

            #4;
            exp_addr = cn ? tg : m_pc + 32'd4;
            adv = cn || (!tk && (!m_valid || id_allow_in));
            chk("valid", 64'(if_to_id_valid), 64'(m_valid && !cn));
            chk("addr", 64'(inst_sram_addr), 64'(exp_addr));
            chk("en", 64'(inst_sram_en), 64'(adv));
            if (m_valid && !cn)
                chk("bus", if_to_id_bus, {mem(m_pc), m_pc});
            if (adv) begin
                m_valid = 1'b1;
                m_pc = exp_addr;
            end

            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
